// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-to-decode queue handshake bundle
interface fetch_queue_if;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_exc;
  logic        out_ready;
  logic        flush;
  logic [2:0]  count;
  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_instr, out_exc, count
  );
  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, out_pc, out_instr, out_exc, count
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular fetch buffer that tags bad fetch addresses, with flush and no bypass
module fetch_queue #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] PC_BASE  = 32'h0000_3000,
  parameter logic [31:0] PC_LIMIT = 32'h0000_6ffc
) (
  input logic          clk,
  input logic          reset,
  fetch_queue_if.slave q
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [2:0] FULL = 3'(DEPTH);
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } entry_t;
  entry_t        mem_q [DEPTH];
  entry_t        head;
  entry_t        new_entry;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [2:0]    count_q, count_d;
  logic          push, pop, bad_pc;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == LAST ? '0 : p + 1'b1;
  endfunction
  assign q.in_ready  = count_q < FULL;
  assign q.out_valid = count_q != 3'd0;
  assign q.count     = count_q;
  assign q.out_pc    = head.pc;
  assign q.out_instr = head.instr;
  assign q.out_exc   = head.exc;
  always_comb begin
    bad_pc    = (|q.in_pc[1:0]) || q.in_pc < PC_BASE || q.in_pc > PC_LIMIT;
    new_entry = '{pc: q.in_pc, instr: bad_pc ? 32'h0 : q.in_instr, exc: bad_pc};
    push      = q.in_valid && q.in_ready && !q.flush;
    pop       = q.out_valid && q.out_ready && !q.flush;
    wr_ptr_d  = q.flush ? '0 : push ? inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = q.flush ? '0 : pop ? inc(rd_ptr_q) : rd_ptr_q;
    count_d   = q.flush ? 3'd0 : count_q + {2'b0, push} - {2'b0, pop};
    head      = q.out_valid ? mem_q[rd_ptr_q] : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= 3'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= new_entry;
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed scoreboard bench for fetch_queue against a queue model
module tb_fetch_queue;
  localparam int DEPTH = 2;
  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam logic [31:0] LIMIT = 32'h0000_6ffc;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  fetch_queue_if bus();
  fetch_queue #(.DEPTH(DEPTH), .PC_BASE(BASE), .PC_LIMIT(LIMIT)) dut (
    .clk(clk),
    .reset(rst),
    .q(bus)
  );
  always #5 clk = ~clk;
  ent_t ref_q[$];
  ent_t sb_q[$];
  ent_t exp_head;
  int   exp_cnt = 0;
  bit   armed = 1'b0;
  int   tests = 0;
  int   fails = 0;
  function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] ins);
    ent_t e;
    e.exc   = (pc % 4 != 0) || pc < BASE || pc > LIMIT;
    e.pc    = pc;
    e.instr = e.exc ? 32'h0 : ins;
    return e;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cycle(input bit r, input bit iv, input logic [31:0] pc, input logic [31:0] ins,
                       input bit ordy, input bit fl);
    int  cur;
    bit  pu, po;
    @(posedge clk);
    #1;
    rst = r;
    bus.in_valid = iv;
    bus.in_pc = pc;
    bus.in_instr = ins;
    bus.out_ready = ordy;
    bus.flush = fl;
    cur = ref_q.size();
    exp_cnt = cur;
    exp_head = cur != 0 ? ref_q[0] : '{32'h0, 32'h0, 1'b0};
    armed = 1'b1;
    po = !r && !fl && ordy && cur > 0;
    pu = !r && !fl && iv && cur < DEPTH;
    if (po) sb_q.push_back(ref_q[0]);
    if (r || fl) ref_q.delete();
    else begin
      if (po) void'(ref_q.pop_front());
      if (pu) ref_q.push_back(mk(pc, ins));
    end
  endtask
  always @(negedge clk) begin
    if (armed) begin
      ent_t e;
      chk("count", 32'(bus.count), 32'(exp_cnt));
      chk("in_ready", 32'(bus.in_ready), 32'(exp_cnt < DEPTH));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_cnt != 0));
      chk("out_pc", bus.out_pc, exp_head.pc);
      chk("out_instr", bus.out_instr, exp_head.instr);
      chk("out_exc", 32'(bus.out_exc), 32'(exp_head.exc));
      if (bus.out_valid && bus.out_ready && !bus.flush && !rst) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop_unexpected: got pc %h expected no pop at %0t", bus.out_pc, $time);
        end else begin
          e = sb_q.pop_front();
          chk("pop_pc", bus.out_pc, e.pc);
          chk("pop_instr", bus.out_instr, e.instr);
          chk("pop_exc", 32'(bus.out_exc), 32'(e.exc));
        end
      end
    end
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_pc = '0;
    bus.in_instr = '0;
    bus.out_ready = 1'b0;
    bus.flush = 1'b0;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 32'h3000, 32'h3c010001, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 1, 32'h3004, 32'h11111111, 0, 0);
    cycle(0, 1, 32'h3008, 32'h22222222, 0, 0);
    cycle(0, 1, 32'h3008, 32'h22222222, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 1, 32'h3000, 32'haaaa0000, 0, 0);
    cycle(0, 1, 32'h3008, 32'hbbbb0000, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 1, 32'h3002, 32'h12345678, 0, 0);
    cycle(0, 1, 32'h2ffc, 32'h33333333, 1, 0);
    cycle(0, 1, 32'h7000, 32'h44444444, 1, 0);
    cycle(0, 1, 32'h6ffc, 32'h55555555, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 1, 32'h3000, 32'h01010101, 0, 0);
    cycle(0, 1, 32'h3004, 32'h02020202, 0, 0);
    cycle(0, 1, 32'h300c, 32'h03030303, 1, 1);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 1, 32'h3000, 32'h01010101, 0, 0);
    cycle(0, 1, 32'h3004, 32'h02020202, 0, 0);
    cycle(1, 1, 32'h300c, 32'h03030303, 1, 1);
    cycle(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] pc;
      pc = $urandom_range(32'h2ff0, 32'h7010);
      if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0, pc, $urandom(),
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end
    repeat (3) cycle(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: got %0d unconsumed expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
